// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: state encoding and occupancy codes.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + PERF_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: head register plus one skid entry, valid/ready handshake,
// flush, bubble injection and a saturating stall counter. All outputs are registered.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              bubble,
  output logic [1:0]        occupancy,
  output logic [PERF_W-1:0] stall_cnt
);

  pipe_state_t       state;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              push;
  logic              pop;
  logic              stall_inc;

  assign push      = in_valid & in_ready & ~bubble & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign stall_inc = in_valid & ~push;

  // Head and skid are cleared whenever they leave the valid set, so the
  // control vector seen downstream is zero while out_valid is low.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= EMPTY;
      out_ctrl  <= '0;
      out_data  <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= OCC_EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state     <= ONE;
            out_ctrl  <= in_ctrl;
            out_data  <= in_data;
            out_valid <= 1'b1;
            occupancy <= OCC_ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
          end else if (push) begin
            state     <= FULL;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            in_ready  <= 1'b0;
            occupancy <= OCC_FULL;
          end else if (pop) begin
            state     <= EMPTY;
            out_ctrl  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            occupancy <= OCC_EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state     <= ONE;
            out_ctrl  <= skid_ctrl;
            out_data  <= skid_data;
            skid_ctrl <= '0;
            skid_data <= '0;
            in_ready  <= 1'b1;
            occupancy <= OCC_ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_ctrl  <= '0;
          out_data  <= '0;
          skid_ctrl <= '0;
          skid_data <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          occupancy <= OCC_EMPTY;
        end
      endcase
    end
  end

  sat_counter #(
    .PERF_W(PERF_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a queue-based reference model compared every
// cycle, plus per-scenario inline checks for latency, back-pressure, flush, bubble, saturation.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 160;
  localparam int PERF_W = 4;
  localparam int SAT    = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic              bubble;
  logic [1:0]        occupancy;
  logic [PERF_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [CTRL_W+DATA_W-1:0] sb[$];
  logic [CTRL_W+DATA_W-1:0] exp_head;
  int  m_stall = 0;
  bit  live = 0;
  bit  m_push;
  bit  m_pop;

  pipe_stage_skid #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .PERF_W(PERF_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .flush    (flush),
    .bubble   (bubble),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mk_data(input int v);
    logic [31:0] w;
    w = 32'(v) ^ 32'h5A5A_0000;
    return {5{w}};
  endfunction

  function automatic logic [CTRL_W-1:0] mk_ctrl(input int v);
    return 16'h8000 | 16'(v);
  endfunction

  // Reference model: inputs are stable at the edge because the bench drives them #1 later.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      m_stall = 0;
      live    = 1;
    end else if (live) begin
      m_push = in_valid && (sb.size() < 2) && !bubble && !flush;
      m_pop  = (sb.size() > 0) && out_ready && !flush;
      if (flush) begin
        sb.delete();
      end else begin
        if (m_pop) void'(sb.pop_front());
        if (m_push) sb.push_back({in_ctrl, in_data});
      end
      if (in_valid && !m_push && m_stall < SAT) m_stall++;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      exp_head = (sb.size() > 0) ? sb[0] : '0;
      total++;
      if (out_valid !== (sb.size() > 0)) begin
        bad++;
        $display("[TB] FAIL sb_valid act=%b exp=%b t=%0t", out_valid, sb.size() > 0, $time);
      end
      total++;
      if ({out_ctrl, out_data} !== exp_head) begin
        bad++;
        $display("[TB] FAIL sb_head act=%h exp=%h t=%0t", {out_ctrl, out_data}, exp_head, $time);
      end
      total++;
      if (occupancy !== 2'(sb.size())) begin
        bad++;
        $display("[TB] FAIL sb_occ act=%0d exp=%0d t=%0t", occupancy, sb.size(), $time);
      end
      total++;
      if (in_ready !== (sb.size() < 2)) begin
        bad++;
        $display("[TB] FAIL sb_in_ready act=%b exp=%b t=%0t", in_ready, sb.size() < 2, $time);
      end
      total++;
      if (stall_cnt !== PERF_W'(m_stall)) begin
        bad++;
        $display("[TB] FAIL sb_stall act=%0d exp=%0d t=%0t", stall_cnt, m_stall, $time);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input int val);
    in_valid = v;
    in_ctrl  = v ? mk_ctrl(val) : '0;
    in_data  = v ? mk_data(val) : '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in_ctrl = 16'hFFFF; in_data = '1;
    out_ready = 1'b0; flush = 1'b0; bubble = 1'b0;
    tick; tick;
    rst = 1'b0;
    set_in(1'b0, 0);
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
      bad++;
      $display("[TB] FAIL reset_out act=%b/%h exp=0/0", out_valid, out_ctrl);
    end
    total++;
    if (in_ready !== 1'b1 || occupancy !== 2'd0 || stall_cnt !== '0) begin
      bad++;
      $display("[TB] FAIL reset_ctl act=%b/%0d/%0d exp=1/0/0", in_ready, occupancy, stall_cnt);
    end
  endtask

  task automatic test_streaming;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, i);
      tick;
      total++;
      if (out_valid !== 1'b1 || out_data !== mk_data(i) || in_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stream_%0d act=%b/%h exp=1/%h", i, out_valid, out_data[31:0], mk_data(i) & 160'hFFFF_FFFF);
      end
    end
    set_in(1'b0, 0);
    tick;
  endtask

  task automatic test_back_pressure;
    out_ready = 1'b0;
    set_in(1'b1, 16'hA1); tick;
    set_in(1'b1, 16'hB2); tick;
    total++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_full act=%0d/%b exp=2/0", occupancy, in_ready);
    end
    set_in(1'b1, 16'hC3); tick; tick;
    total++;
    if (out_data !== mk_data(16'hA1) || stall_cnt !== 4'd2) begin
      bad++;
      $display("[TB] FAIL bp_hold act=%h/%0d exp=A1/2", out_data[15:0], stall_cnt);
    end
    out_ready = 1'b1;
    tick;
    total++;
    if (out_data !== mk_data(16'hB2) || occupancy !== 2'd1 || stall_cnt !== 4'd3) begin
      bad++;
      $display("[TB] FAIL bp_rel1 act=%h/%0d/%0d exp=B2/1/3", out_data[15:0], occupancy, stall_cnt);
    end
    tick;
    set_in(1'b0, 0);
    total++;
    if (out_data !== mk_data(16'hC3) || out_ctrl !== mk_ctrl(16'hC3)) begin
      bad++;
      $display("[TB] FAIL bp_rel2 act=%h exp=C3", out_data[15:0]);
    end
    tick;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    set_in(1'b1, 16'h71); tick;
    set_in(1'b1, 16'h72); tick;
    set_in(1'b1, 16'hD4);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    total++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== '0 || stall_cnt !== 4'd4) begin
      bad++;
      $display("[TB] FAIL flush act=%0d/%b/%h/%0d exp=0/0/0/4", occupancy, out_valid, out_ctrl, stall_cnt);
    end
    set_in(1'b1, 16'hE5);
    out_ready = 1'b1;
    tick;
    set_in(1'b0, 0);
    total++;
    if (out_valid !== 1'b1 || out_data !== mk_data(16'hE5)) begin
      bad++;
      $display("[TB] FAIL flush_next act=%b/%h exp=1/E5", out_valid, out_data[15:0]);
    end
    tick;
  endtask

  task automatic test_bubble;
    out_ready = 1'b0;
    set_in(1'b1, 16'h60); tick;
    set_in(1'b1, 16'hF6);
    bubble = 1'b1; out_ready = 1'b1;
    tick;
    bubble = 1'b0;
    total++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || stall_cnt !== 4'd5) begin
      bad++;
      $display("[TB] FAIL bubble act=%0d/%b/%0d exp=0/0/5", occupancy, out_valid, stall_cnt);
    end
    tick;
    set_in(1'b0, 0);
    total++;
    if (occupancy !== 2'd1 || out_data !== mk_data(16'hF6)) begin
      bad++;
      $display("[TB] FAIL bubble_next act=%0d/%h exp=1/F6", occupancy, out_data[15:0]);
    end
    tick;
  endtask

  task automatic test_saturation;
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      set_in(1'b1, 16'h100 + i);
      tick;
    end
    total++;
    if (stall_cnt !== 4'd15) begin
      bad++;
      $display("[TB] FAIL saturate act=%0d exp=15", stall_cnt);
    end
    set_in(1'b0, 0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    total++;
    if (occupancy !== 2'd0 || stall_cnt !== 4'd15) begin
      bad++;
      $display("[TB] FAIL sat_flush act=%0d/%0d exp=0/15", occupancy, stall_cnt);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_back_pressure;
    test_flush;
    test_bubble;
    test_saturation;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
